// File: rtl/mat4_pkg.sv
// rtl/mat4_pkg.sv - shared constants, state encoding and index helper for mat4_stream_bridge
package mat4_pkg;

  localparam int N     = 4;
  localparam int NELEM = 16;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  function automatic int elem_idx(input int row, input int col);
    return row * N + col;
  endfunction

endpackage

// File: rtl/mat4_elem_ctr.sv
// rtl/mat4_elem_ctr.sv - 5-bit element slot counter with clear, enable and terminal-count wrap
module mat4_elem_ctr (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic [4:0] tc_val,
  output logic [4:0] count,
  output logic       tc
);

  assign tc = (count == tc_val);

  // An enabled step at the terminal value wraps to zero for the next phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr || (en && tc)) begin
      count <= '0;
    end else if (en) begin
      count <= count + 5'd1;
    end
  end

endmodule

// File: rtl/mat4_stream_bridge.sv
// rtl/mat4_stream_bridge.sv - streams A/B into a 4x4 multiplier, starts it, drains C as a stream
module mat4_stream_bridge
  import mat4_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int MUL_LAT = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [WIDTH-1:0]       s_data,
  output logic                   mul_start,
  output logic [WIDTH*NELEM-1:0] mul_a,
  output logic [WIDTH*NELEM-1:0] mul_b,
  input  logic [WIDTH*NELEM-1:0] mul_c,
  input  logic                   mul_done,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [WIDTH-1:0]       m_data,
  output logic                   m_last,
  output logic                   busy
);

  localparam int             LW       = (MUL_LAT < 1) ? 1 : $clog2(MUL_LAT + 1);
  localparam logic [LW-1:0]  LAT_MAX  = LW'(MUL_LAT);
  localparam logic [4:0]     LAST_IN  = 5'(2 * NELEM - 1);
  localparam logic [4:0]     LAST_OUT = 5'(elem_idx(N - 1, N - 1));

  state_t            state;
  logic [LW-1:0]     lat_cnt;
  logic [WIDTH-1:0]  a_mem [NELEM];
  logic [WIDTH-1:0]  b_mem [NELEM];
  logic [WIDTH-1:0]  c_mem [NELEM];
  logic [4:0]        cnt;
  logic              cnt_tc;
  logic              s_fire;
  logic              m_fire;
  logic              capture;

  assign s_ready   = (state == LOAD);
  assign busy      = (state != LOAD);
  assign mul_start = (state == START);
  assign m_valid   = (state == DRAIN);
  assign m_last    = m_valid && cnt_tc;
  assign m_data    = m_valid ? c_mem[cnt[3:0]] : '0;

  assign s_fire  = s_ready && s_valid;
  assign m_fire  = m_valid && m_ready;
  // Done is only trusted once the minimum latency has elapsed, so a sticky flag is harmless
  assign capture = (state == WAIT) && (lat_cnt == LAT_MAX) && mul_done;

  mat4_elem_ctr u_ctr (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (capture),
    .en     (s_fire || m_fire),
    .tc_val ((state == DRAIN) ? LAST_OUT : LAST_IN),
    .count  (cnt),
    .tc     (cnt_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= LOAD;
      lat_cnt <= '0;
    end else begin
      case (state)
        LOAD:  if (s_fire && cnt_tc) state <= START;
        START: begin
          lat_cnt <= '0;
          state   <= WAIT;
        end
        WAIT: begin
          if (lat_cnt != LAT_MAX) lat_cnt <= lat_cnt + 1'b1;
          if (capture) state <= DRAIN;
        end
        DRAIN: if (m_fire && cnt_tc) state <= LOAD;
        default: state <= LOAD;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NELEM; k++) begin
        a_mem[k] <= '0;
        b_mem[k] <= '0;
      end
    end else if (s_fire) begin
      if (!cnt[4]) a_mem[cnt[3:0]] <= s_data;
      else         b_mem[cnt[3:0]] <= s_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NELEM; k++) c_mem[k] <= '0;
    end else if (capture) begin
      for (int k = 0; k < NELEM; k++) c_mem[k] <= mul_c[k*WIDTH +: WIDTH];
    end
  end

  for (genvar k = 0; k < NELEM; k++) begin : g_flat
    assign mul_a[k*WIDTH +: WIDTH] = a_mem[k];
    assign mul_b[k*WIDTH +: WIDTH] = b_mem[k];
  end

endmodule

// File: tb/tb_mat4_stream_bridge.sv
// tb/tb_mat4_stream_bridge.sv - directed-vector bench for mat4_stream_bridge with a multiplier model
module tb_mat4_stream_bridge;
  import mat4_pkg::*;

  localparam int MUL_LAT = 3;

  typedef logic [15:0] vec_t [16];

  logic          clk = 1'b0;
  logic          rst_n;
  logic          s_valid, s_ready;
  logic [15:0]   s_data;
  logic          mul_start;
  logic [255:0]  mul_a, mul_b;
  logic [255:0]  mul_c = '0;
  logic          mul_done;
  logic          m_valid, m_ready;
  logic [15:0]   m_data;
  logic          m_last, busy;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int start_c = 0, first_v = 0, n_start = 0;
  bit got_first = 1'b1;

  bit   sticky = 1'b0;
  int   done_delay = 3;
  logic done_r = 1'b0;
  bit   running = 1'b0;
  int   dly = 0;
  vec_t ma, mb;

  mat4_stream_bridge #(.WIDTH(16), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b), .mul_c(mul_c), .mul_done(mul_done),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] mm(input vec_t a, input vec_t b, input int k);
    logic [15:0] s;
    s = '0;
    for (int i = 0; i < 4; i++) s = s + a[(k / 4) * 4 + i] * b[i * 4 + (k % 4)];
    return s;
  endfunction

  // Multiplier model: C appears done_delay cycles after the start pulse, never earlier
  assign mul_done = sticky ? 1'b1 : done_r;
  always @(posedge clk) begin
    if (mul_start) begin
      for (int k = 0; k < 16; k++) begin
        ma[k] = mul_a[k*16 +: 16];
        mb[k] = mul_b[k*16 +: 16];
      end
      running <= 1'b1;
      dly     <= 1;
      if (!sticky) done_r <= 1'b0;
    end else if (running) begin
      dly <= dly + 1;
      if (dly == done_delay) begin
        for (int k = 0; k < 16; k++) mul_c[k*16 +: 16] <= mm(ma, mb, k);
        done_r  <= 1'b1;
        running <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (mul_start) begin
      start_c   = cyc;
      got_first = 1'b0;
      n_start++;
    end
    if (m_valid && !got_first) begin
      first_v   = cyc;
      got_first = 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
    end
  endtask

  task automatic send_job(input vec_t a, input vec_t b, input int n, input bit gaps);
    int t;
    for (int w = 0; w < n; w++) begin
      if (gaps) begin
        s_valid = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      s_valid = 1'b1;
      s_data  = (w < 16) ? a[w] : b[w - 16];
      t = 0;
      while (!s_ready && t < 200) begin
        @(negedge clk);
        t++;
      end
      if (!s_ready) begin
        chk("send s_ready timeout", s_ready, 1);
        break;
      end
      @(negedge clk);
    end
    s_valid = 1'b0;
  endtask

  task automatic recv_job(input vec_t exp, input bit bp, input string tag);
    int k, t, ph;
    bit stalled;
    logic [15:0] held;
    logic [3:0] pat;
    k = 0; t = 0; ph = 0; stalled = 1'b0; held = '0; pat = 4'b1001;
    while (k < 16 && t < 400) begin
      m_ready = bp ? pat[3 - (ph % 4)] : 1'b1;
      ph++;
      if (m_valid) begin
        if (stalled) chk({tag, " held data"}, m_data, held);
        if (m_ready) begin
          chk({tag, " data"}, m_data, exp[k]);
          chk({tag, " last"}, m_last, (k == 15));
          k++;
          stalled = 1'b0;
        end else begin
          held    = m_data;
          stalled = 1'b1;
        end
      end
      @(negedge clk);
      t++;
    end
    m_ready = 1'b0;
    if (k < 16) chk({tag, " drain count"}, k, 16);
  endtask

  task automatic wait_start();
    int t;
    t = 0;
    while (!mul_start && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("mul_start seen", mul_start, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t ia, ib, ex, za, wa, wb, ra, rb;
    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst s_ready", s_ready, 1);
    chk("rst busy", busy, 0);
    chk("rst mul_start", mul_start, 0);
    chk("rst m_valid", m_valid, 0);
    chk("rst m_last", m_last, 0);
    chk("rst m_data", m_data, 0);
    chk("rst mul_a", mul_a == '0, 1);
    chk("rst mul_b", mul_b == '0, 1);
    rst_n = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 16; k++) begin
      ia[k] = '0;
      ib[k] = 16'(k + 1);
      ex[k] = 16'(k + 1);
    end
    for (int i = 0; i < 4; i++) ia[elem_idx(i, i)] = 16'd1;
    send_job(ia, ib, 32, 1'b0);
    recv_job(ex, 1'b0, "ident");
    chk("ident latency", first_v - start_c, MUL_LAT + 2);

    for (int k = 0; k < 16; k++) begin
      wa[k] = 16'h0100;
      za[k] = 16'h0000;
    end
    send_job(wa, wa, 32, 1'b0);
    recv_job(za, 1'b0, "wrap0");
    for (int k = 0; k < 16; k++) begin
      wa[k] = 16'd1;
      wb[k] = 16'd2;
      ex[k] = 16'd8;
    end
    send_job(wa, wb, 32, 1'b0);
    recv_job(ex, 1'b0, "wrap8");

    for (int k = 0; k < 16; k++) begin
      ra[k] = 16'($urandom_range(0, 65535));
      rb[k] = 16'($urandom_range(0, 65535));
    end
    for (int k = 0; k < 16; k++) ex[k] = mm(ra, rb, k);
    send_job(ra, rb, 32, 1'b1);
    recv_job(ex, 1'b1, "bp");

    sticky = 1'b1;
    for (int k = 0; k < 16; k++) ex[k] = 16'(k + 1);
    send_job(ia, ib, 32, 1'b0);
    recv_job(ex, 1'b0, "sticky1");
    chk("sticky1 latency", first_v - start_c, MUL_LAT + 2);
    for (int k = 0; k < 16; k++) ex[k] = 16'd8;
    send_job(wa, wb, 32, 1'b0);
    recv_job(ex, 1'b0, "sticky2");
    chk("sticky2 latency", first_v - start_c, MUL_LAT + 2);
    sticky = 1'b0;

    done_delay = 10;
    send_job(ra, rb, 32, 1'b0);
    wait_start();
    repeat (6) @(negedge clk);
    chk("slow busy", busy, 1);
    chk("slow m_valid", m_valid, 0);
    chk("slow s_ready", s_ready, 0);
    for (int k = 0; k < 16; k++) ex[k] = mm(ra, rb, k);
    recv_job(ex, 1'b0, "slow");
    chk("slow latency", first_v - start_c, 12);
    done_delay = 3;

    send_job(ra, rb, 20, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("abort s_ready", s_ready, 1);
    chk("abort busy", busy, 0);
    chk("abort m_valid", m_valid, 0);
    chk("abort mul_a", mul_a == '0, 1);
    chk("abort mul_b", mul_b == '0, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 16; k++) begin
      ib[k] = 16'(16 - k);
      ex[k] = 16'(16 - k);
    end
    send_job(ia, ib, 32, 1'b0);
    recv_job(ex, 1'b0, "post_rst");

    chk("start pulses", n_start, 8);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mat4_stream_bridge.md
# mat4_stream_bridge

- Host-side initiator for the 4x4 matrix multiplier's start/done interface.
- Receives A then B as a 32-element valid/ready stream and assembles the flattened operands.
- Issues a single start pulse, waits for a qualified done, captures C, then streams its 16 elements out.
- Sits between the DMA/host stream fabric and the multiplier core.

## Interface

Parameters:
- WIDTH, 16, element width in bits; all elements are unsigned.
- MUL_LAT, 3, minimum number of cycles after mul_start before mul_done is believed.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- s_valid  in  1  input element valid.
- s_ready  out  1  input element ready.
- s_data  in  WIDTH  input element.
- mul_start  out  1  one-cycle start pulse to the multiplier.
- mul_a  out  WIDTH*16  flattened A; element k is at [k*WIDTH +: WIDTH].
- mul_b  out  WIDTH*16  flattened B; same layout as mul_a.
- mul_c  in  WIDTH*16  flattened C from the multiplier.
- mul_done  in  1  multiplier done; may be level or sticky.
- m_valid  out  1  output element valid.
- m_ready  in  1  output element ready.
- m_data  out  WIDTH  output element.
- m_last  out  1  high on the 16th output element.
- busy  out  1  high in every state except LOAD.

## Operation

- Element index k = row*4 + col (row-major); k = 0 travels first on both streams.
- FSM states and transitions:
  - LOAD: s_ready=1. Each s_valid&&s_ready handshake writes s_data to slot cnt. cnt 0..15 fill mul_a[cnt]; cnt 16..31 fill mul_b[cnt-16]. The handshake at cnt==31 clears cnt and moves to START.
  - START: mul_start=1 for exactly this one cycle. Clears lat_cnt and moves to WAIT.
  - WAIT: lat_cnt increments and saturates at MUL_LAT. When lat_cnt==MUL_LAT && mul_done: capture mul_c into c_reg, clear cnt, move to DRAIN.
  - DRAIN: m_valid=1, m_data=c_reg[cnt], m_last=(cnt==15). Each handshake increments cnt. The handshake at cnt==15 moves to LOAD.
- mul_a and mul_b change only on LOAD handshakes. They hold stable from START through DRAIN.
- Arithmetic wraps mod 2^WIDTH inside the multiplier. The bridge passes values bit-exact and does not check overflow.
- mul_done high before MUL_LAT cycles is ignored. This tolerates a done flag left sticky from the previous job.
- Boundary conditions:
  - s_ready=0 outside LOAD; extra input words back-pressure.
  - m_valid held with m_ready=0: m_data and m_last stay stable.
  - Gaps in s_valid or m_ready are allowed at any point.
  - Reset asserted mid-job aborts the job. Partial operands and C are discarded, and the next job loads from k=0.
  - mul_done is never observed outside WAIT.

## Timing

- Reset values:
  - State=LOAD, cnt=0, lat_cnt=0.
  - s_ready=1, busy=0.
  - mul_start=0, m_valid=0, m_last=0, m_data=0.
  - mul_a=0, mul_b=0, c_reg=0.
- Throughput: one element per cycle on each stream when unthrottled.
- Last B handshake at cycle T:
  - mul_start is high in cycle T+1.
  - The earliest capture is in cycle T+2+MUL_LAT.
  - The first m_valid follows in the next cycle.
- Unthrottled job: 32 + 1 + MUL_LAT + 1 + 16 cycles, plus any extra wait for mul_done.
- All outputs are registered or decoded from state/cnt only. There is no combinational path from s_valid or m_ready to any output.

## Structure

- Package mat4_pkg holds:
  - N=4 and NELEM=16.
  - The state enum {LOAD, START, WAIT, DRAIN}.
  - Function elem_idx(row,col) returning row*N+col.
- One sub-module: mat4_elem_ctr. It is a 5-bit up-counter with clear, enable and terminal-count compare, used for both cnt phases.
- WIDTH stays a module parameter.

## Test plan

- Identity: A=I, B has element k = k+1. The output stream is 1..16 in order, with m_last on the 16th element only.
- Wrap: all A = 0x0100, all B = 0x0100 (WIDTH=16). Every output is 0x0000. With all A=1 and all B=2, every output is 0x0008.
- Backpressure: s_valid randomly gapped and m_ready toggling 1-0-0-1. Results match the golden model, and m_data never changes while m_valid&&!m_ready.
- Sticky done: the multiplier model holds mul_done=1 permanently. Capture occurs exactly MUL_LAT+1 cycles after mul_start (no stale C), across two back-to-back jobs.
- Slow done: mul_done rises 10 cycles after start. The bridge stays in WAIT with busy=1 and m_valid=0 until then.
- Reset mid-job: rst_n pulsed low after 20 input words. State returns to LOAD with s_ready=1 and all outputs at reset values. A following full 32-word job produces the correct C.
